state_history_display: RTL and testbench

//  Downstream stage of the input state monitor. Consumes the settled 8-bit input value the monitor

---
 rtl/state_history_display_pkg.sv | 24 ++
 rtl/state_history_display_seg_hex_decoder.sv | 13 +
 rtl/state_history_display.sv | 128 ++++++++++++
 tb/tb_state_history_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/state_history_display_pkg.sv
// Segment encodings and shared state types for the input-state-monitor display path.
// The monitor and the history display both use these glyph constants.
package state_history_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Index n holds the {g,f,e,d,c,b,a} glyph for hex digit n.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    NIB_LOW  = 1'b0,
    NIB_HIGH = 1'b1
  } nib_sel_e;

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_e;

endpackage

// File: rtl/state_history_display_seg_hex_decoder.sv
// Combinational hex nibble to 7-segment glyph decoder.
module seg_hex_decoder
  import state_history_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_GLYPH[nibble];
  end

endmodule

// File: rtl/state_history_display.sv
// Keeps a short history of settled monitor values and shows one entry on a 7-segment digit,
// alternating high/low nibble, with a blinking dash while a transient window is open.
module state_history_display
  import state_history_display_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DIGIT_TICKS = 5000,
  parameter int unsigned BLINK_TICKS = 2500
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       settle_valid,
  input  logic [7:0]                 settle_data,
  input  logic                       in_transient,
  input  logic                       clear,
  input  logic [$clog2(DEPTH)-1:0]   view_sel,
  output logic [6:0]                 seg_out,
  output logic                       dp_out,
  output logic [$clog2(DEPTH):0]     hist_count,
  output logic [7:0]                 event_cnt
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned PW = $clog2(DIGIT_TICKS);
  localparam int unsigned BW = $clog2(BLINK_TICKS);

  logic [7:0]    hist_q [DEPTH];
  nib_sel_e      sel_q, sel_d;
  logic [PW-1:0] phase_q, phase_d;
  blink_e        blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [6:0]    seg_d;
  logic          dp_d;

  // History shift register and event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      hist_count <= '0;
      event_cnt  <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      hist_count <= '0;
      event_cnt  <= '0;
    end else if (settle_valid) begin
      for (int unsigned i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
      hist_q[0] <= settle_data;
      if (hist_count != CW'(DEPTH)) hist_count <= hist_count + CW'(1);
      if (event_cnt != '1) event_cnt <= event_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= NIB_HIGH;
      phase_q <= '0;
      blink_q <= BLINK_ON;
      bcnt_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    sel_d   = sel_q;
    phase_d = phase_q;
    blink_d = blink_q;
    bcnt_d  = bcnt_q;

    // A fresh value restarts the phase so its high nibble is shown first
    if (clear || settle_valid) begin
      phase_d = '0;
      sel_d   = NIB_HIGH;
    end else if (phase_q == PW'(DIGIT_TICKS - 1)) begin
      phase_d = '0;
      sel_d   = (sel_q == NIB_HIGH) ? NIB_LOW : NIB_HIGH;
    end else begin
      phase_d = phase_q + PW'(1);
    end

    if (clear || !in_transient) begin
      bcnt_d  = '0;
      blink_d = BLINK_ON;
    end else if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
      bcnt_d  = '0;
      blink_d = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end else begin
      bcnt_d  = bcnt_q + BW'(1);
    end
  end

  assign nib = (sel_q == NIB_HIGH) ? hist_q[view_sel][7:4] : hist_q[view_sel][3:0];

  seg_hex_decoder u_dec (
    .nibble (nib),
    .seg    (glyph)
  );

  always_comb begin
    seg_d = glyph;
    dp_d  = (sel_q == NIB_HIGH);
    if (in_transient) begin
      seg_d = (blink_q == BLINK_ON) ? SEG_DASH : SEG_BLANK;
      dp_d  = 1'b0;
    end else if ({1'b0, view_sel} >= hist_count) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b0;
    end else begin
      seg_out <= seg_d;
      dp_out  <= dp_d;
    end
  end

endmodule

// File: tb/tb_state_history_display.sv
// Scoreboard bench for state_history_display: a queue-based reference model predicts each
// registered output update, and an independent monitor pops and compares after every edge.
module tb_state_history_display;

  localparam int D  = 4;
  localparam int DT = 6;
  localparam int BT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       settle_valid = 1'b0;
  logic [7:0] settle_data = '0;
  logic       in_transient = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] view_sel = '0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [2:0] hist_count;
  logic [7:0] event_cnt;

  state_history_display #(
    .DEPTH       (D),
    .DIGIT_TICKS (DT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .settle_valid (settle_valid),
    .settle_data  (settle_data),
    .in_transient (in_transient),
    .clear        (clear),
    .view_sel     (view_sel),
    .seg_out      (seg_out),
    .dp_out       (dp_out),
    .hist_count   (hist_count),
    .event_cnt    (event_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [2:0] hc;
    logic [7:0] ev;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [6:0] glyph_tb [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: history as a queue (newest first), plus edge counts since the
  // last phase restart and since the transient window opened.
  logic [7:0] m_hist[$];
  int m_ev, m_phk, m_blk;

  task automatic model_reset();
    m_hist.delete();
    m_ev  = 0;
    m_phk = 0;
    m_blk = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic sv, input logic [7:0] d,
                       input logic tr, input logic clr, input logic [1:0] vs);
    exp_t e;
    bit high, on;
    logic [7:0] b;
    @(negedge clk);
    rst_n = rst; settle_valid = sv; settle_data = d;
    in_transient = tr; clear = clr; view_sel = vs;
    if (!rst) begin
      model_reset();
      e.seg = '0; e.dp = 1'b0; e.hc = '0; e.ev = '0;
    end else begin
      high = ((m_phk / DT) % 2) == 0;
      on   = ((m_blk / BT) % 2) == 0;
      if (tr) begin
        e.seg = on ? 7'h40 : 7'h00;
        e.dp  = 1'b0;
      end else if (int'(vs) >= m_hist.size()) begin
        e.seg = 7'h00;
        e.dp  = 1'b0;
      end else begin
        b     = m_hist[vs];
        e.seg = glyph_tb[high ? b[7:4] : b[3:0]];
        e.dp  = high;
      end
      if (clr) begin
        m_hist.delete();
        m_ev = 0;
      end else if (sv) begin
        m_hist.push_front(d);
        if (m_hist.size() > D) void'(m_hist.pop_back());
        if (m_ev < 255) m_ev++;
      end
      m_phk = (clr || sv) ? 0 : m_phk + 1;
      m_blk = (clr || !tr) ? 0 : m_blk + 1;
      e.hc = 3'(m_hist.size());
      e.ev = 8'(m_ev);
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic tr, input logic [1:0] vs);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00, tr, 1'b0, vs);
  endtask

  // Monitor: one registered update per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("seg_out",    int'(seg_out),    int'(e.seg));
        chk("dp_out",     int'(dp_out),     int'(e.dp));
        chk("hist_count", int'(hist_count), int'(e.hc));
        chk("event_cnt",  int'(event_cnt),  int'(e.ev));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic tr_r;
    logic [1:0] vs_r;
    model_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);

    // A5: high nibble first, low nibble after DIGIT_TICKS
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 2'd0);
    idle(2 * DT + 3, 1'b0, 2'd0);

    // Overfill the history; view the oldest retained entry (22)
    foreach (m_hist[i]) ; // no-op keeps model untouched
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 2'd3);
    idle(2 * DT + 2, 1'b0, 2'd3);

    // Blank for unpopulated entry, then blinking dash, with a push inside the window
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2);
    drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 2'd2);
    idle(3, 1'b0, 2'd2);
    idle(2 * BT + 1, 1'b1, 2'd0);
    drive(1'b1, 1'b1, 8'h9C, 1'b1, 1'b0, 2'd0);
    idle(2 * BT + 2, 1'b1, 2'd0);
    idle(3, 1'b0, 2'd0);

    // Clear wins over a simultaneous push; event counter saturation
    drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 2'd0);
    idle(2, 1'b0, 2'd0);
    for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 2'd1);
    idle(2, 1'b0, 2'd1);

    // Push while the low nibble is showing restarts the phase on the high nibble
    idle(DT + 2, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 8'h3B, 1'b0, 1'b0, 2'd0);
    idle(DT + 2, 1'b0, 2'd0);

    // Asynchronous reset mid-cycle, observed without a clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg",   int'(seg_out),    0);
    chk("async_rst_dp",    int'(dp_out),     0);
    chk("async_rst_count", int'(hist_count), 0);
    chk("async_rst_event", int'(event_cnt),  0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);

    // Randomized traffic
    tr_r = 1'b0;
    vs_r = 2'd0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) tr_r = ~tr_r;
      if ($urandom_range(0, 9) == 0) vs_r = 2'($urandom_range(0, 3));
      drive(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom), tr_r,
            ($urandom_range(0, 99) == 0), vs_r);
    end
    idle(2, 1'b0, 2'd0);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
